prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader for the simulation/FPGA top level. Consumes a byte stream (UART receiver or testbench) carrying an image header, instruction lines and data words, and writes them into instruction memory (128-bit lines) and data memory (32-bit words) through the top-level `prog_*` load muxes. It holds the pipeline in reset via `prog_loading` until the image is fully written, then releases it and flags `loaded`.

## Interface
- `ADDR_LEN`, 32, byte-address width of `prog_loadaddr`
- `IMEM_LINES`, 512, instruction-memory capacity in 128-bit lines
- `DMEM_WORDS`, 4096, data-memory capacity in 32-bit words
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high
- `rx_data` in 8: stream byte
- `rx_valid` in 1: one-cycle byte strobe, may be high every cycle; no backpressure
- `reload` in 1: one-cycle pulse, restarts loading from DONE or ERROR
- `prog_loading` out 1: high while loading; the top level ORs it into core reset
- `prog_loaddata` out 128: write data; dmem uses bits [127:96]
- `prog_loadaddr` out ADDR_LEN: byte address of current write
- `prog_imem_we` out 1: one-cycle imem line write strobe
- `prog_dmem_we` out 1: one-cycle dmem word write strobe
- `loaded` out 1: image complete, core running
- `load_err` out 1: header count exceeds capacity

## Operation
- Stream format: 4-byte header = imem line count N_I (16 bit, LE), then dmem word count N_D (16 bit, LE); then 16·N_I imem bytes; then 4·N_D dmem bytes.
- Every 4 bytes form one 32-bit word, little-endian (first byte → bits [7:0]).
- Imem line: the 4 words shift into the line register from the low end; the first word of a line ends up in [127:96], the fourth in [31:0].
- Dmem word: placed in [127:96]; [95:0] driven 0.
- States: HDR → IMEM → DMEM → DONE; ERROR terminal until `reload`/`reset`.
  - HDR: collect 4 bytes. On the 4th: if N_I > IMEM_LINES or N_D > DMEM_WORDS → ERROR; else → IMEM (N_I≠0), DMEM (N_I=0, N_D≠0), or DONE (both 0).
  - IMEM: on every 16th byte, issue a line write at address 16·line_idx, increment line_idx; after line N_I → DMEM or DONE (N_D=0).
  - DMEM: on every 4th byte, issue a word write at address 4·word_idx; after word N_D → DONE.
  - DONE: `prog_loading`=0, `loaded`=1; `rx_valid` ignored. `reload` → HDR, clears counters, `prog_loading`=1, `loaded`=0.
  - ERROR: `load_err`=1, `prog_loading` stays 1; `rx_valid` ignored; `reload` → HDR and clears `load_err`.
- Reset values: state HDR, `prog_loading`=1, all other outputs 0, counters 0.
- Reset asserted mid-load aborts immediately; no partial write strobe escapes.

## Timing
- Write strobe, data and address are registered: asserted for exactly one cycle, in the cycle after the completing byte's `rx_valid` edge; data/addr are stable in that cycle.
- Back-to-back bytes every cycle are sustained; consecutive imem writes are ≥16 cycles apart, dmem writes ≥4 cycles apart.
- `prog_imem_we` and `prog_dmem_we` are never high together.
- Transition to DONE coincides with the final write strobe cycle; `prog_loading` drops and `loaded` rises in the next cycle, so the last write completes while the core is still in reset.
- `reload` in HDR/IMEM/DMEM is ignored.

## Structure
- Shared constants (state encodings, header length 4, line bytes 16) go in the common define/constants header.
- One sub-module: `byte_word_asm` — 4-byte LE assembler with byte counter, `word_valid` pulse output, synchronous clear; instantiated once, feeds line shift register and dmem path.

## Test plan
- Header N_I=1, N_D=0, bytes 0x00..0x0F → one `prog_imem_we`, addr 0, data 0x03020100_07060504_0B0A0908_0F0E0D0C; `loaded`=1 next cycle.
- N_I=0, N_D=2, words 0xDEADBEEF, 0x12345678 (LE bytes) → two `prog_dmem_we` at addr 0 and 4, [127:96] matching, [95:0]=0; `loaded`=1.
- N_I=2, N_D=1, bytes every cycle → imem writes at 0x00, 0x10 exactly 16 cycles apart, then dmem at 0x00; strobes never overlap.
- Header N_I=513 → ERROR, `load_err`=1, `prog_loading`=1, no strobes on further bytes; `reload` → HDR, `load_err`=0.
- Assert `reset` after 10 of 16 imem bytes → no strobe, `prog_loading`=1; fresh full image then loads correctly from addr 0.
- Header N_I=0, N_D=0 → DONE after 4 bytes, no writes; `reload` then a second image → `loaded` drops, reloads, rises.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_loader_pkg                                                  |
// | Purpose : Shared types and constants for the boot-time program loader:     |
// |           loader state encoding, stream geometry, byte-address helpers.    |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_IMEM  = 3'd1,
    ST_DMEM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned WORDS_PER_LINE = LINE_BYTES / WORD_BYTES;
  localparam int unsigned CNT_W          = 16;

  // Byte address of instruction line number idx.
  function automatic logic [31:0] line_addr(input logic [CNT_W-1:0] idx);
    return 32'(idx) * LINE_BYTES;
  endfunction

  // Byte address of data word number idx.
  function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
    return 32'(idx) * WORD_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_loader_if                                                   |
// | Purpose : Byte-stream input and prog_* load-mux outputs of the loader.     |
// | Ports   : rx_data/rx_valid/reload  (stream side -> loader)                 |
// |           prog_loading/prog_loaddata/prog_loadaddr/prog_imem_we/           |
// |           prog_dmem_we/loaded/load_err (loader -> top level)               |
// |           modport slave  : loader view                                     |
// |           modport master : stream source / top-level view                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface prog_loader_if #(
  parameter int unsigned ADDR_LEN = 32
);

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                reload;
  logic                prog_loading;
  logic [127:0]        prog_loaddata;
  logic [ADDR_LEN-1:0] prog_loadaddr;
  logic                prog_imem_we;
  logic                prog_dmem_we;
  logic                loaded;
  logic                load_err;

  modport slave (
    input  rx_data, rx_valid, reload,
    output prog_loading, prog_loaddata, prog_loadaddr,
           prog_imem_we, prog_dmem_we, loaded, load_err
  );

  modport master (
    output rx_data, rx_valid, reload,
    input  prog_loading, prog_loaddata, prog_loadaddr,
           prog_imem_we, prog_dmem_we, loaded, load_err
  );

endinterface
`default_nettype wire

// File: rtl/prog_loader_byte_word_asm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : byte_word_asm                                                    |
// | Purpose : Assembles 4 consecutive stream bytes into a little-endian 32-bit |
// |           word (first byte -> [7:0]).                                      |
// | Ports   : clk, rst            clock, async active-high reset               |
// |           clr_i               synchronous clear of the byte counter        |
// |           byte_i/byte_valid_i incoming byte and its strobe                 |
// |           word_o/word_valid_o assembled word, valid in the cycle the 4th   |
// |                               byte is presented (combinational pulse)      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module byte_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] bytes_q;

  // Bytes shift in from the top so that after three bytes the oldest sits
  // in [7:0]; the fourth byte is appended combinationally as [31:24].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      bytes_q <= 24'd0;
    end else if (clr_i) begin
      cnt_q   <= 2'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      bytes_q <= {byte_i, bytes_q[23:8]};
    end
  end

  assign word_o       = {byte_i, bytes_q};
  assign word_valid_o = byte_valid_i && !clr_i && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_loader                                                      |
// | Purpose : Boot-time program loader. Parses a byte stream (header, imem     |
// |           lines, dmem words) and writes it through the prog_* load muxes,  |
// |           holding the core in reset until the image is complete.           |
// | Ports   : clk    clock                                                     |
// |           reset  async active-high reset                                   |
// |           bus    prog_loader_if.slave (stream in, load-mux outputs)        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned IMEM_LINES = 512,
  parameter int unsigned DMEM_WORDS = 4096
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    ni_q, ni_d;
  logic [CNT_W-1:0]    nd_q, nd_d;
  logic [CNT_W-1:0]    lidx_q, lidx_d;
  logic [CNT_W-1:0]    widx_q, widx_d;
  logic [1:0]          wic_q, wic_d;
  logic [95:0]         line_q, line_d;
  logic                imem_we_q, imem_we_d;
  logic                dmem_we_q, dmem_we_d;
  logic [127:0]        data_q, data_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                loading_q, loaded_q, err_q;

  logic                asm_clr;
  logic                byte_en;
  logic [31:0]         word;
  logic                word_valid;

  // Bytes are only consumed while an image is in flight.
  assign byte_en = bus.rx_valid &&
                   ((state_q == ST_HDR) || (state_q == ST_IMEM) || (state_q == ST_DMEM));

  byte_word_asm u_asm (
    .clk          (clk),
    .rst          (reset),
    .clr_i        (asm_clr),
    .byte_i       (bus.rx_data),
    .byte_valid_i (byte_en),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HDR;
      ni_q      <= '0;
      nd_q      <= '0;
      lidx_q    <= '0;
      widx_q    <= '0;
      wic_q     <= 2'd0;
      line_q    <= '0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      loading_q <= 1'b1;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ni_q      <= ni_d;
      nd_q      <= nd_d;
      lidx_q    <= lidx_d;
      widx_q    <= widx_d;
      wic_q     <= wic_d;
      line_q    <= line_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      // Status lags the state by one cycle so the final write strobe
      // still lands while the core is held in reset.
      loading_q <= (state_q != ST_DONE);
      loaded_q  <= (state_q == ST_DONE);
      err_q     <= (state_q == ST_ERROR);
    end
  end

  always_comb begin
    state_d   = state_q;
    ni_d      = ni_q;
    nd_d      = nd_q;
    lidx_d    = lidx_q;
    widx_d    = widx_q;
    wic_d     = wic_q;
    line_d    = line_q;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    asm_clr   = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (word_valid) begin
          ni_d = word[15:0];
          nd_d = word[31:16];
          if (({16'h0, word[15:0]} > IMEM_LINES) ||
              ({16'h0, word[31:16]} > DMEM_WORDS)) begin
            state_d = ST_ERROR;
          end else if (word[15:0] != '0) begin
            state_d = ST_IMEM;
          end else if (word[31:16] != '0) begin
            state_d = ST_DMEM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_IMEM: begin
        if (word_valid) begin
          // Words enter at the low end; the first word of a line is pushed
          // up to [127:96] by the time the fourth arrives.
          line_d = {line_q[63:0], word};
          wic_d  = wic_q + 2'd1;
          if (wic_q == 2'(WORDS_PER_LINE - 1)) begin
            imem_we_d = 1'b1;
            data_d    = {line_q, word};
            addr_d    = ADDR_LEN'(line_addr(lidx_q));
            lidx_d    = lidx_q + 1'b1;
            if ((lidx_q + 1'b1) == ni_q) begin
              state_d = (nd_q != '0) ? ST_DMEM : ST_DONE;
            end
          end
        end
      end

      ST_DMEM: begin
        if (word_valid) begin
          dmem_we_d = 1'b1;
          data_d    = {word, 96'h0};
          addr_d    = ADDR_LEN'(word_addr(widx_q));
          widx_d    = widx_q + 1'b1;
          if ((widx_q + 1'b1) == nd_q) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE, ST_ERROR: begin
        if (bus.reload) begin
          state_d = ST_HDR;
          ni_d    = '0;
          nd_d    = '0;
          lidx_d  = '0;
          widx_d  = '0;
          wic_d   = 2'd0;
          asm_clr = 1'b1;
        end
      end

      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  assign bus.prog_loading  = loading_q;
  assign bus.prog_loaddata = data_q;
  assign bus.prog_loadaddr = addr_q;
  assign bus.prog_imem_we  = imem_we_q;
  assign bus.prog_dmem_we  = dmem_we_q;
  assign bus.loaded        = loaded_q;
  assign bus.load_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_prog_loader                                                   |
// | Purpose : Directed self-checking bench for prog_loader.                    |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_LEN(32)) bus ();

  prog_loader #(
    .ADDR_LEN   (32),
    .IMEM_LINES (512),
    .DMEM_WORDS (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Strobe log, sampled on the falling edge.
  int           cyc        = 0;
  int           overlap    = 0;
  int           loaded_rise = -1;
  logic         loaded_prev = 1'b0;
  logic [127:0] im_data[$];
  logic [31:0]  im_addr[$];
  int           im_cyc[$];
  logic         im_loading[$];
  logic [127:0] dm_data[$];
  logic [31:0]  dm_addr[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.prog_imem_we && bus.prog_dmem_we) overlap++;
    if (bus.prog_imem_we) begin
      im_data.push_back(bus.prog_loaddata);
      im_addr.push_back(bus.prog_loadaddr);
      im_cyc.push_back(cyc);
      im_loading.push_back(bus.prog_loading);
    end
    if (bus.prog_dmem_we) begin
      dm_data.push_back(bus.prog_loaddata);
      dm_addr.push_back(bus.prog_loadaddr);
    end
    if (bus.loaded && !loaded_prev) loaded_rise = cyc;
    loaded_prev = bus.loaded;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] imd(input int i);
    return (i < im_data.size()) ? im_data[i] : 'x;
  endfunction
  function automatic logic [31:0] ima(input int i);
    return (i < im_addr.size()) ? im_addr[i] : 'x;
  endfunction
  function automatic int imc(input int i);
    return (i < im_cyc.size()) ? im_cyc[i] : -1000;
  endfunction
  function automatic logic [127:0] dmd(input int i);
    return (i < dm_data.size()) ? dm_data[i] : 'x;
  endfunction
  function automatic logic [31:0] dma(input int i);
    return (i < dm_addr.size()) ? dm_addr[i] : 'x;
  endfunction

  task automatic clr_log();
    im_data.delete(); im_addr.delete(); im_cyc.delete(); im_loading.delete();
    dm_data.delete(); dm_addr.delete();
    loaded_rise = -1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] ni, input logic [15:0] nd);
    put_byte(ni[7:0]); put_byte(ni[15:8]);
    put_byte(nd[7:0]); put_byte(nd[15:8]);
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) put_byte(first + 8'(i));
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  localparam logic [127:0] LINE_00 = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
  localparam logic [127:0] LINE_20 = 128'h23222120_27262524_2B2A2928_2F2E2D2C;
  localparam logic [127:0] LINE_30 = 128'h33323130_37363534_3B3A3938_3F3E3D3C;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_loading", bus.prog_loading, 1);
    chk("rst_loaded",  bus.loaded, 0);
    chk("rst_err",     bus.load_err, 0);
    chk("rst_we",      {bus.prog_imem_we, bus.prog_dmem_we}, 0);
    chk("rst_addr",    bus.prog_loadaddr, 0);
    chk("rst_data",    bus.prog_loaddata, 0);
    reset = 1'b0;
    @(negedge clk);

    // One imem line, no dmem
    clr_log();
    send_hdr(16'd1, 16'd0);
    send_seq(8'h00, 16);
    idle(3);
    chk("t1_nimem",   im_data.size(), 1);
    chk("t1_ndmem",   dm_data.size(), 0);
    chk("t1_addr",    ima(0), 32'h0);
    chk("t1_data",    imd(0), LINE_00);
    chk("t1_loading_at_we", (im_loading.size() > 0) ? im_loading[0] : 1'bx, 1);
    chk("t1_loaded_lag", 32'(loaded_rise - imc(0)), 1);
    chk("t1_loaded",  bus.loaded, 1);
    chk("t1_loading", bus.prog_loading, 0);

    // Two dmem words
    pulse_reload();
    idle(2);
    chk("t2_reload_loaded",  bus.loaded, 0);
    chk("t2_reload_loading", bus.prog_loading, 1);
    clr_log();
    send_hdr(16'd0, 16'd2);
    put_byte(8'hEF); put_byte(8'hBE); put_byte(8'hAD); put_byte(8'hDE);
    put_byte(8'h78); put_byte(8'h56); put_byte(8'h34); put_byte(8'h12);
    idle(3);
    chk("t2_ndmem",  dm_data.size(), 2);
    chk("t2_nimem",  im_data.size(), 0);
    chk("t2_addr0",  dma(0), 32'h0);
    chk("t2_data0",  dmd(0), {32'hDEADBEEF, 96'h0});
    chk("t2_addr1",  dma(1), 32'h4);
    chk("t2_data1",  dmd(1), {32'h12345678, 96'h0});
    chk("t2_loaded", bus.loaded, 1);

    // Two lines plus one word, bytes every cycle
    pulse_reload();
    idle(2);
    clr_log();
    send_hdr(16'd2, 16'd1);
    send_seq(8'h20, 32);
    put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
    idle(3);
    chk("t3_nimem",  im_data.size(), 2);
    chk("t3_addr0",  ima(0), 32'h00);
    chk("t3_data0",  imd(0), LINE_20);
    chk("t3_addr1",  ima(1), 32'h10);
    chk("t3_data1",  imd(1), LINE_30);
    chk("t3_gap",    32'(imc(1) - imc(0)), 16);
    chk("t3_ndmem",  dm_data.size(), 1);
    chk("t3_daddr",  dma(0), 32'h0);
    chk("t3_ddata",  dmd(0), {32'hDDCCBBAA, 96'h0});
    chk("t3_loaded", bus.loaded, 1);

    // Oversized imem count
    pulse_reload();
    idle(2);
    clr_log();
    send_hdr(16'd513, 16'd0);
    idle(2);
    chk("t4_err",     bus.load_err, 1);
    chk("t4_loading", bus.prog_loading, 1);
    chk("t4_loaded",  bus.loaded, 0);
    send_seq(8'h00, 20);
    idle(2);
    chk("t4_nwrites", im_data.size() + dm_data.size(), 0);
    chk("t4_err_hold", bus.load_err, 1);
    pulse_reload();
    idle(2);
    chk("t4_reload_err",     bus.load_err, 0);
    chk("t4_reload_loading", bus.prog_loading, 1);

    // Reset mid-line, then a clean image
    clr_log();
    send_hdr(16'd1, 16'd0);
    send_seq(8'h40, 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_nwrites", im_data.size() + dm_data.size(), 0);
    chk("t5_loading", bus.prog_loading, 1);
    reset = 1'b0;
    @(negedge clk);
    clr_log();
    send_hdr(16'd1, 16'd0);
    send_seq(8'h00, 16);
    idle(3);
    chk("t5_nimem", im_data.size(), 1);
    chk("t5_addr",  ima(0), 32'h0);
    chk("t5_data",  imd(0), LINE_00);

    // Empty image, then reload a real one
    pulse_reload();
    idle(2);
    clr_log();
    send_hdr(16'd0, 16'd0);
    idle(3);
    chk("t6_loaded",  bus.loaded, 1);
    chk("t6_loading", bus.prog_loading, 0);
    chk("t6_nwrites", im_data.size() + dm_data.size(), 0);
    pulse_reload();
    idle(2);
    chk("t6_reload_loaded", bus.loaded, 0);
    send_hdr(16'd1, 16'd0);
    send_seq(8'h00, 16);
    idle(3);
    chk("t6_nimem",  im_data.size(), 1);
    chk("t6_data",   imd(0), LINE_00);
    chk("t6_loaded2", bus.loaded, 1);

    // Dmem capacity boundary: 4097 rejected, 4096 accepted
    pulse_reload();
    idle(2);
    clr_log();
    send_hdr(16'd0, 16'd4097);
    idle(2);
    chk("t7_err_over", bus.load_err, 1);
    pulse_reload();
    idle(2);
    send_hdr(16'd0, 16'd4096);
    idle(2);
    chk("t7_err_cap",  bus.load_err, 0);
    chk("t7_loading",  bus.prog_loading, 1);
    send_seq(8'h50, 8);
    idle(2);
    chk("t7_ndmem",  dm_data.size(), 2);
    chk("t7_addr1",  dma(1), 32'h4);
    chk("t7_data1",  dmd(1), {32'h57565554, 96'h0});
    chk("t7_loaded", bus.loaded, 0);

    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
